// File: rtl/mac_pkg.sv
// Shared widths and FSM state encoding for the product accumulator.
package mac_pkg;

    localparam int unsigned MAC_PROD_W = 52;
    localparam int unsigned MAC_ACC_W  = 56;
    localparam int unsigned MAC_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } mac_state_e;

endpackage : mac_pkg

// File: rtl/sat_add_56b.sv
// Saturating unsigned adder for the accumulator.
// Ports:
//   a, b  : ACC_W operands (b is the zero-extended product)
//   sum   : a + b, forced to all-ones when the add carries out
//   carry : carry out of the ACC_W-bit add
module sat_add_56b
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = MAC_ACC_W
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] raw;

    always_comb begin
        raw   = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        carry = raw[ACC_W];
        sum   = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
    end

endmodule : sat_add_56b

// File: rtl/mult_accumulator_52b.sv
// Accumulates a run of len unsigned products into a saturating wide sum and
// hands the result over with a valid/ready handshake.
// Ports:
//   clk, rstn            : clock, async active-low reset
//   start, len           : begin a run of len products (IDLE only)
//   clr                  : synchronous abort back to IDLE, clears acc/cnt/ovf
//   prod_in, prod_valid  : product stream from the multiplier
//   acc_out, out_valid   : result, held stable until out_ready
//   out_ready            : consumer accepts result
//   busy                 : run in progress or result pending
//   ovf                  : sticky saturation flag for the run
module mult_accumulator_52b
    import mac_pkg::*;
#(
    parameter int unsigned PROD_W = MAC_PROD_W,
    parameter int unsigned ACC_W  = MAC_ACC_W,
    parameter int unsigned CNT_W  = MAC_CNT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              clr,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              ovf
);

    mac_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [ACC_W-1:0] sum_sat;
    logic             sum_carry;

    sat_add_56b #(.ACC_W(ACC_W)) u_sat_add (
        .a     (acc_q),
        .b     (ACC_W'(prod_in)),
        .sum   (sum_sat),
        .carry (sum_carry)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and datapath update; flags are derived from the next state
    // so that every output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (prod_valid) begin
                    acc_d = sum_sat;
                    ovf_d = ovf_q | sum_carry;
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    if (cnt_q == CNT_W'(len_q - CNT_W'(1))) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything, including a product in flight
        if (clr) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end

        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    assign acc_out   = acc_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule : mult_accumulator_52b

// File: tb/tb_mult_accumulator_52b.sv
// Directed scoreboard bench for mult_accumulator_52b.
module tb_mult_accumulator_52b;
    import mac_pkg::*;

    localparam int unsigned PW = MAC_PROD_W;
    localparam int unsigned AW = MAC_ACC_W;
    localparam int unsigned CW = MAC_CNT_W;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [CW-1:0] len;
    logic          clr;
    logic [PW-1:0] prod_in;
    logic          prod_valid;
    logic [AW-1:0] acc_out;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          ovf;

    typedef struct packed {
        logic [AW-1:0] acc;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [PW-1:0] P_MAX   = 52'hF_FFFF_FFFF_FFFF;
    localparam logic [AW-1:0] A_16MAX = 56'hFF_FFFF_FFFF_FFF0;
    localparam logic [AW-1:0] A_ONES  = 56'hFF_FFFF_FFFF_FFFF;

    mult_accumulator_52b dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .len        (len),
        .clr        (clr),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .acc_out    (acc_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: compares every handshake against the queued expectation
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got acc=%0h with nothing expected", acc_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (acc_out !== e.acc || ovf !== e.ovf) begin
                    fails++;
                    $display("FAIL sb_result: got acc=%0h ovf=%0b expected acc=%0h ovf=%0b",
                             acc_out, ovf, e.acc, e.ovf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] p);
        prod_in    = p;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic begin_run(input int n);
        start = 1'b1;
        len   = CW'(n);
        tick();
        start = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; len = '0; clr = 1'b0;
        prod_in = '0; prod_valid = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_acc",   64'(acc_out),   64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_ovf",   64'(ovf),       64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // 1: three back-to-back products
        exp_q.push_back('{acc: AW'(6), ovf: 1'b0});
        begin_run(3);
        check("t1_busy", 64'(busy), 64'd1);
        send(1); send(2); send(3);
        check("t1_valid", 64'(out_valid), 64'd1);
        tick();
        check("t1_valid_drop", 64'(out_valid), 64'd0);
        check("t1_busy_drop",  64'(busy),      64'd0);
        check("t1_acc_hold",   64'(acc_out),   64'd6);

        // 2: bubbles between products
        exp_q.push_back('{acc: AW'(100), ovf: 1'b0});
        begin_run(4);
        send(10);
        tick(); tick();
        check("t2_bubble_hold", 64'(acc_out), 64'd10);
        send(20); tick();
        send(30); tick(); tick(); tick();
        check("t2_acc_60",    64'(acc_out),   64'd60);
        check("t2_not_done",  64'(out_valid), 64'd0);
        send(40);
        check("t2_valid", 64'(out_valid), 64'd1);
        tick();

        // 3: saturation on the 17th max product
        exp_q.push_back('{acc: A_ONES, ovf: 1'b1});
        begin_run(17);
        for (int i = 0; i < 16; i++) send(P_MAX);
        check("t3_acc16", 64'(acc_out), 64'(A_16MAX));
        check("t3_ovf16", 64'(ovf),     64'd0);
        send(P_MAX);
        check("t3_acc17", 64'(acc_out), 64'(A_ONES));
        check("t3_ovf17", 64'(ovf),     64'd1);
        tick();

        // 4: backpressure, start pulses ignored while result pending
        out_ready = 1'b0;
        exp_q.push_back('{acc: AW'(12), ovf: 1'b0});
        begin_run(2);
        send(5); send(7);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 64'(out_valid), 64'd1);
            check("t4_hold_acc",   64'(acc_out),   64'd12);
            start = 1'b1; len = CW'(1);
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("t4_valid6", 64'(out_valid), 64'd1);
        check("t4_acc6",   64'(acc_out),   64'd12);
        tick();
        check("t4_idle_busy", 64'(busy), 64'd0);

        // 5a: zero-length run
        exp_q.push_back('{acc: AW'(0), ovf: 1'b0});
        begin_run(0);
        check("t5_len0_valid", 64'(out_valid), 64'd1);
        check("t5_len0_acc",   64'(acc_out),   64'd0);
        tick();

        // 5b: abort mid-run, product alongside clr is dropped
        begin_run(5);
        send(3); send(4);
        check("t5_partial", 64'(acc_out), 64'd7);
        clr = 1'b1; prod_in = PW'(100); prod_valid = 1'b1;
        tick();
        clr = 1'b0; prod_valid = 1'b0;
        check("t5_clr_acc",   64'(acc_out), 64'd0);
        check("t5_clr_busy",  64'(busy),    64'd0);
        repeat (4) tick();
        check("t5_clr_novalid", 64'(out_valid), 64'd0);

        // 6: async reset between edges, then a fresh run
        begin_run(3);
        send(1);
        #2 rstn = 1'b0;
        #1;
        check("t6_rst_acc",  64'(acc_out), 64'd0);
        check("t6_rst_busy", 64'(busy),    64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        exp_q.push_back('{acc: AW'(9), ovf: 1'b0});
        begin_run(1);
        send(9);
        check("t6_valid", 64'(out_valid), 64'd1);
        tick(); tick();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mult_accumulator_52b
